// File: rtl/rst_seq.sv
// Reset sequencer: qualifies clock lock, holds all domain resets for a minimum time,
// then releases them one at a time (bit 0 first) with a fixed gap between releases.
module rst_seq #(
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned LOCK_CYC  = 4,
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned STAGE_DLY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock,
    input  logic             sw_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned LW = $clog2(LOCK_CYC) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYC) + 1;
    localparam int unsigned SW = $clog2(STAGE_DLY) + 1;
    localparam int unsigned IW = $clog2(N_OUT) + 1;

    localparam logic [LW-1:0] LockLast  = LW'(LOCK_CYC - 1);
    localparam logic [HW-1:0] HoldLast  = HW'(HOLD_CYC - 1);
    localparam logic [SW-1:0] StageLast = SW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(N_OUT - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StHold,
        StRelease,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]     stage_cnt_q, stage_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_OUT-1:0]  rst_out_q, rst_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sw_prev_q;
    logic              sw_edge;

    assign sw_edge = sw_req & ~sw_prev_q;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        stage_cnt_d = stage_cnt_q;
        idx_d       = idx_q;
        rst_out_d   = rst_out_q;

        unique case (state_q)
            StWaitLock: begin
                rst_out_d = '1;
                if (!lock) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LockLast) begin
                    state_d    = StHold;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            StHold: begin
                rst_out_d = '1;
                if (hold_cnt_q == HoldLast) begin
                    state_d     = StRelease;
                    hold_cnt_d  = '0;
                    stage_cnt_d = '0;
                    idx_d       = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            StRelease: begin
                if (stage_cnt_q == StageLast) begin
                    stage_cnt_d = '0;
                    // Clearing only the indexed bit keeps rst_out a thermometer code.
                    for (int i = 0; i < int'(N_OUT); i++) begin
                        if (idx_q == IW'(i)) rst_out_d[i] = 1'b0;
                    end
                    if (idx_q == IdxLast) begin
                        state_d = StRun;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    stage_cnt_d = stage_cnt_q + SW'(1);
                end
            end
            StRun: begin
                rst_out_d = '0;
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        // Abort paths override normal progress; lock loss outranks a software request.
        if (state_q != StWaitLock) begin
            if (!lock) begin
                state_d     = StWaitLock;
                lock_cnt_d  = '0;
                hold_cnt_d  = '0;
                stage_cnt_d = '0;
                idx_d       = '0;
                rst_out_d   = '1;
            end else if (sw_edge) begin
                state_d     = StHold;
                lock_cnt_d  = '0;
                hold_cnt_d  = '0;
                stage_cnt_d = '0;
                idx_d       = '0;
                rst_out_d   = '1;
            end
        end

        busy_d = (state_d != StRun);
        done_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitLock;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
            rst_out_q   <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            // Preset high so a request held through reset is not seen as an edge.
            sw_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            idx_q       <= idx_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sw_prev_q   <= sw_req;
        end
    end

    assign rst_out = rst_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: checkpoint table for the basic sequence plus
// hand-built lock-loss, software-request and reset corner cases against a timeline model.
module tb_rst_seq;

    localparam int N     = 4;
    localparam int LOCK  = 4;
    localparam int HOLD  = 16;
    localparam int STG   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         lock;
    logic         sw_req;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    rst_seq #(
        .N_OUT    (N),
        .LOCK_CYC (LOCK),
        .HOLD_CYC (HOLD),
        .STAGE_DLY(STG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .lock   (lock),
        .sw_req (sw_req),
        .rst_out(rst_out),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [N-1:0] r;
        logic         b;
        logic         d;
    } exp_t;

    typedef struct {
        int           e;
        logic [N-1:0] r;
        logic         b;
        logic         d;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   hold_start = -1;

    // Expected outputs after edge e when HOLD was entered at edge h (h<0: not yet).
    function automatic exp_t model(input int e, input int h);
        exp_t x;
        int   rel;
        rel = 0;
        if (h >= 0 && e >= h + HOLD) rel = (e - h - HOLD) / STG;
        if (rel > N) rel = N;
        x.r = '1;
        for (int i = 0; i < N; i++) begin
            if (i < rel) x.r[i] = 1'b0;
        end
        x.d = (rel == N);
        x.b = (rel != N);
        return x;
    endfunction

    task automatic tick(input logic l, input logic s, input bit chk, input exp_t e,
                        input string name);
        exp_t x;
        lock   = l;
        sw_req = s;
        if (chk) sb.push_back(e);
        @(posedge clk);
        edge_n++;
        #1;
        if (chk) begin
            x = sb.pop_front();
            checks++;
            if (rst_out !== x.r || busy !== x.b || done !== x.d) begin
                errors++;
                $display("FAIL %s edge %0d: got rst_out=%b busy=%b done=%b, want rst_out=%b busy=%b done=%b",
                         name, edge_n, rst_out, busy, done, x.r, x.b, x.d);
            end
        end
    endtask

    task automatic run_model(input logic l, input logic s, input int n, input string name);
        for (int i = 0; i < n; i++) tick(l, s, 1'b1, model(edge_n + 1, hold_start), name);
    endtask

    task automatic do_reset(input logic s);
        exp_t e;
        e.r = '1;
        e.b = 1'b1;
        e.d = 1'b0;
        rst = 1'b1;
        tick(1'b1, s, 1'b1, e, "reset");
        tick(1'b1, s, 1'b1, e, "reset");
        rst        = 1'b0;
        edge_n     = 0;
        hold_start = 4;
    endtask

    task automatic run_table(input int shift, input int glitch, input string name);
        exp_t e;
        exp_t dummy;
        dummy = '{r: '0, b: 1'b0, d: 1'b0};
        for (int i = 0; i < 11; i++) begin
            while (edge_n + 1 < vecs[i].e + shift) begin
                tick(logic'(edge_n + 1 != glitch), 1'b0, 1'b0, dummy, name);
            end
            e.r = vecs[i].r;
            e.b = vecs[i].b;
            e.d = vecs[i].d;
            tick(logic'(edge_n + 1 != glitch), 1'b0, 1'b1, e, name);
        end
    endtask

    initial begin
        vecs[0]  = '{e: 1,  r: 4'b1111, b: 1'b1, d: 1'b0};
        vecs[1]  = '{e: 4,  r: 4'b1111, b: 1'b1, d: 1'b0};
        vecs[2]  = '{e: 20, r: 4'b1111, b: 1'b1, d: 1'b0};
        vecs[3]  = '{e: 27, r: 4'b1111, b: 1'b1, d: 1'b0};
        vecs[4]  = '{e: 28, r: 4'b1110, b: 1'b1, d: 1'b0};
        vecs[5]  = '{e: 35, r: 4'b1110, b: 1'b1, d: 1'b0};
        vecs[6]  = '{e: 36, r: 4'b1100, b: 1'b1, d: 1'b0};
        vecs[7]  = '{e: 44, r: 4'b1000, b: 1'b1, d: 1'b0};
        vecs[8]  = '{e: 51, r: 4'b1000, b: 1'b1, d: 1'b0};
        vecs[9]  = '{e: 52, r: 4'b0000, b: 1'b0, d: 1'b1};
        vecs[10] = '{e: 60, r: 4'b0000, b: 1'b0, d: 1'b1};

        rst    = 1'b1;
        lock   = 1'b1;
        sw_req = 1'b0;

        // Basic sequence with lock tied high.
        do_reset(1'b0);
        run_table(0, -1, "t1 basic");

        // Lock loss in RUN, plus a software request while waiting for lock (ignored).
        hold_start = edge_n + 1 + LOCK;
        run_model(1'b0, 1'b0, 1, "t3 lock loss");
        run_model(1'b1, 1'b0, 1, "t3 relock");
        run_model(1'b1, 1'b1, 1, "t3 sw in wait");
        run_model(1'b1, 1'b0, 60, "t3 rerun");

        // One-cycle lock glitch at edge 3 shifts everything by 3.
        do_reset(1'b0);
        run_table(3, 3, "t2 glitch");

        // Software request right after bit 1 releases.
        do_reset(1'b0);
        run_model(1'b1, 1'b0, 36, "t4 pre");
        hold_start = edge_n + 1;
        run_model(1'b1, 1'b1, 1, "t4 req");
        run_model(1'b1, 1'b0, 52, "t4 rerun");

        // Request held through reset does not fire; one drop/raise restarts exactly once.
        do_reset(1'b1);
        run_model(1'b1, 1'b1, 56, "t5 held");
        run_model(1'b1, 1'b0, 1, "t5 drop");
        hold_start = edge_n + 1;
        run_model(1'b1, 1'b1, 60, "t5 reraise");

        // Lock loss and request edge together: lock loss wins.
        run_model(1'b1, 1'b0, 1, "t6 setup");
        hold_start = edge_n + 1 + LOCK;
        run_model(1'b0, 1'b1, 1, "t6 both");
        run_model(1'b1, 1'b1, 30, "t6 relock");

        // Reset asserted mid-HOLD restarts edge-1 timing.
        run_model(1'b1, 1'b0, 1, "t6 drop");
        hold_start = edge_n + 1;
        run_model(1'b1, 1'b1, 5, "t6 hold");
        do_reset(1'b1);
        run_model(1'b1, 1'b1, 53, "t6 post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
